// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_seq_pkg                                                      |
// | Purpose  : Shared types and constants for the next-PC sequencer.           |
// |            state_t      - sequencer FSM states                             |
// |            redir_kind_t - redirect source; numeric value is its priority   |
// |            INST_BYTES   - sequential fetch increment                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    STALL      = 2'd2,
    STALL_PEND = 2'd3
  } state_t;

  // Larger value wins arbitration, so plain unsigned compares rank requests.
  typedef enum logic [1:0] {
    RK_NONE = 2'd0,
    RK_BR   = 2'd1,
    RK_MRET = 2'd2,
    RK_TRAP = 2'd3
  } redir_kind_t;

  localparam int INST_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_prio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_redirect_prio                                                |
// | Purpose  : Combinational arbiter: picks the winning redirect {kind,target} |
// |            from the live trap/mret/branch requests and the pending slot.   |
// | Ports    : trap_i/mtvec_i, mret_i/mepc_i, br_taken_i/br_target_i  live    |
// |            pend_kind_i/pend_target_i   buffered redirect (RK_NONE = empty) |
// |            sel_kind_o/sel_target_o     winner (RK_NONE = nothing to do)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pc_redirect_prio
  import pc_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            trap_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic [1:0]      pend_kind_i,
  input  logic [XLEN-1:0] pend_target_i,
  output logic [1:0]      sel_kind_o,
  output logic [XLEN-1:0] sel_target_o
);

  logic [1:0]      w_live_kind;
  logic [XLEN-1:0] w_live_target;

  always_comb begin
    w_live_kind   = RK_NONE;
    w_live_target = br_target_i;
    if (trap_i) begin
      w_live_kind   = RK_TRAP;
      w_live_target = mtvec_i;
    end else if (mret_i) begin
      w_live_kind   = RK_MRET;
      w_live_target = mepc_i;
    end else if (br_taken_i) begin
      w_live_kind   = RK_BR;
      w_live_target = br_target_i;
    end

    // A live request takes the slot on a tie, so a newer request of equal
    // rank replaces the buffered one.
    if ((w_live_kind != RK_NONE) && (w_live_kind >= pend_kind_i)) begin
      sel_kind_o   = w_live_kind;
      sel_target_o = w_live_target;
    end else begin
      sel_kind_o   = pend_kind_i;
      sel_target_o = pend_target_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_sequencer                                                    |
// | Purpose  : Next-PC controller for the 3-stage RV32 pipeline. Chooses       |
// |            between trap/mret/branch redirects, stall hold and sequential   |
// |            fetch; buffers a redirect raised under stall; flushes IF/EX and |
// |            counts applied redirects (saturating).                          |
// | Ports    : clk, rst (async, active-high)                                   |
// |            pc_cur_i            current PC from the PC register             |
// |            stall_i             hold fetch this cycle                       |
// |            br_taken_i/target   EX branch/jump                              |
// |            trap_i/mtvec_i      trap request / vector                       |
// |            mret_i/mepc_i       mret / return address                       |
// |            pc_next_o           next PC (combinational)                     |
// |            flush_o             kill IF/EX instruction                      |
// |            misalign_o          applied target had nonzero [1:0]            |
// |            redir_cnt_o         applied redirect count, saturating          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_cur_i,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic             mret_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  state_t          r_state;
  logic [1:0]      r_pend_kind;
  logic [XLEN-1:0] r_pend_target;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]      w_sel_kind;
  logic [XLEN-1:0] w_sel_target;
  logic            w_apply;

  pc_redirect_prio #(
    .XLEN (XLEN)
  ) u_prio (
    .trap_i        (trap_i),
    .mtvec_i       (mtvec_i),
    .mret_i        (mret_i),
    .mepc_i        (mepc_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .pend_kind_i   (r_pend_kind),
    .pend_target_i (r_pend_target),
    .sel_kind_o    (w_sel_kind),
    .sel_target_o  (w_sel_target)
  );

  // Pend is empty outside STALL_PEND, so the arbiter output is simply the
  // live winner in RUN/STALL and the live-vs-pend winner in STALL_PEND.
  assign w_apply = (r_state != BOOT) && !stall_i && (w_sel_kind != RK_NONE);

  always_comb begin
    pc_next_o  = pc_cur_i + XLEN'(INST_BYTES);
    flush_o    = 1'b0;
    misalign_o = 1'b0;
    if (rst || (r_state == BOOT)) begin
      pc_next_o = RESET_VECTOR;
      flush_o   = 1'b1;
    end else if (stall_i) begin
      pc_next_o = pc_cur_i;
    end else if (w_apply) begin
      pc_next_o  = {w_sel_target[XLEN-1:2], 2'b00};
      flush_o    = 1'b1;
      misalign_o = |w_sel_target[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pend_kind   <= RK_NONE;
      r_pend_target <= '0;
      r_cnt         <= '0;
    end else begin
      if (r_state == BOOT) begin
        r_state <= RUN;
      end else if (stall_i) begin
        // Re-latching the arbiter winner keeps pend when the live request
        // ranks lower and replaces it otherwise.
        if (w_sel_kind != RK_NONE) begin
          r_pend_kind   <= w_sel_kind;
          r_pend_target <= w_sel_target;
          r_state       <= STALL_PEND;
        end else begin
          r_state <= STALL;
        end
      end else begin
        r_pend_kind <= RK_NONE;
        r_state     <= RUN;
      end

      if (w_apply && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign redir_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_sequencer                                                 |
// | Purpose  : Self-checking bench for pc_sequencer: directed scenarios with   |
// |            literal expectations, then randomized traffic compared every    |
// |            cycle against a behavioural next-PC model.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam int          CNT_W = 8;
  localparam int          CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XLEN-1:0]  pc_cur_i;
  logic             stall_i = 1'b0;
  logic             br_taken_i = 1'b0;
  logic [XLEN-1:0]  br_target_i = '0;
  logic             trap_i = 1'b0;
  logic [XLEN-1:0]  mtvec_i = '0;
  logic             mret_i = 1'b0;
  logic [XLEN-1:0]  mepc_i = '0;
  logic [XLEN-1:0]  pc_next_o;
  logic             flush_o;
  logic             misalign_o;
  logic [CNT_W-1:0] redir_cnt_o;

  // Bench-side PC register; pc_force lets a test inject arbitrary PCs.
  logic [XLEN-1:0] pc_reg;
  logic            use_reg = 1'b1;
  logic [XLEN-1:0] pc_force = '0;
  assign pc_cur_i = use_reg ? pc_reg : pc_force;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= RV;
    else     pc_reg <= pc_next_o;
  end

  pc_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur_i    (pc_cur_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .trap_i      (trap_i),
    .mtvec_i     (mtvec_i),
    .mret_i      (mret_i),
    .mepc_i      (mepc_i),
    .pc_next_o   (pc_next_o),
    .flush_o     (flush_o),
    .misalign_o  (misalign_o),
    .redir_cnt_o (redir_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int          m_boot  = 1;
  int          m_pkind = 0;
  logic [31:0] m_ptgt  = '0;
  int          m_cnt   = 0;

  always @(negedge clk) begin
    int          live;
    logic [31:0] ltgt;
    logic [31:0] e_pc;
    logic [31:0] tgt;
    logic        e_fl;
    logic        e_mis;
    logic        take;
    if (rst) begin
      check("m_rst_pc", pc_next_o, RV);
      check("m_rst_flush", {31'b0, flush_o}, 32'd1);
      check("m_rst_mis", {31'b0, misalign_o}, 32'd0);
      check("m_rst_cnt", {24'b0, redir_cnt_o}, 32'd0);
      m_boot = 1; m_pkind = 0; m_cnt = 0;
    end else if (m_boot != 0) begin
      check("m_boot_pc", pc_next_o, RV);
      check("m_boot_flush", {31'b0, flush_o}, 32'd1);
      check("m_boot_cnt", {24'b0, redir_cnt_o}, m_cnt);
      m_boot = 0;
    end else begin
      live = trap_i ? 3 : mret_i ? 2 : br_taken_i ? 1 : 0;
      ltgt = trap_i ? mtvec_i : mret_i ? mepc_i : br_target_i;
      e_fl = 1'b0; e_mis = 1'b0; take = 1'b0; tgt = '0;
      if (stall_i) begin
        e_pc = pc_cur_i;
        if (live != 0 && live >= m_pkind) begin
          m_pkind = live; m_ptgt = ltgt;
        end
      end else begin
        if (live != 0 && live >= m_pkind) begin take = 1'b1; tgt = ltgt; end
        else if (m_pkind != 0)             begin take = 1'b1; tgt = m_ptgt; end
        if (take) begin
          e_pc  = tgt & 32'hFFFF_FFFC;
          e_fl  = 1'b1;
          e_mis = (tgt[1:0] != 2'b00);
        end else begin
          e_pc = pc_cur_i + 32'd4;
        end
        m_pkind = 0;
      end
      check("m_pc", pc_next_o, e_pc);
      check("m_flush", {31'b0, flush_o}, {31'b0, e_fl});
      check("m_mis", {31'b0, misalign_o}, {31'b0, e_mis});
      check("m_cnt", {24'b0, redir_cnt_o}, m_cnt);
      if (take && m_cnt < CMAX) m_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
    rst = 1'b0; stall_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; br_taken_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 check("boot_pc", pc_next_o, 32'h0); check("boot_flush", {31'b0, flush_o}, 32'd1);
    next_cyc(); #2 check("seq4", pc_next_o, 32'h4); check("seq4_flush", {31'b0, flush_o}, 32'd0);
    next_cyc(); #2 check("seq8", pc_next_o, 32'h8);
    next_cyc(); #2 check("seqC", pc_next_o, 32'hC); check("seq_cnt", {24'b0, redir_cnt_o}, 32'd0);

    // Branch in RUN
    next_cyc(); use_reg = 1'b0; pc_force = 32'h100; br_taken_i = 1'b1; br_target_i = 32'h200;
    #2 check("br_pc", pc_next_o, 32'h200); check("br_flush", {31'b0, flush_o}, 32'd1);
    next_cyc(); pc_force = 32'h200;
    #2 check("br_flush_once", {31'b0, flush_o}, 32'd0); check("br_cnt", {24'b0, redir_cnt_o}, 32'd1);

    // Stall with pending branch, overwritten by a trap
    next_cyc(); pc_force = 32'h210; stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h300;
    #2 check("st1_pc", pc_next_o, 32'h210);
    next_cyc(); stall_i = 1'b1; trap_i = 1'b1; mtvec_i = 32'h80;
    #2 check("st2_pc", pc_next_o, 32'h210); check("st2_flush", {31'b0, flush_o}, 32'd0);
    next_cyc(); stall_i = 1'b1;
    #2 check("st3_pc", pc_next_o, 32'h210);
    next_cyc();
    #2 check("rel_pc", pc_next_o, 32'h80); check("rel_flush", {31'b0, flush_o}, 32'd1);
    next_cyc(); pc_force = 32'h80;
    #2 check("rel_cnt", {24'b0, redir_cnt_o}, 32'd2);

    // Simultaneous requests, then misaligned branch
    next_cyc(); trap_i = 1'b1; mtvec_i = 32'h40; mret_i = 1'b1; mepc_i = 32'h500;
    br_taken_i = 1'b1; br_target_i = 32'h600;
    #2 check("prio_pc", pc_next_o, 32'h40);
    next_cyc(); br_taken_i = 1'b1; br_target_i = 32'h206;
    #2 check("mis_pc", pc_next_o, 32'h204); check("mis_flag", {31'b0, misalign_o}, 32'd1);
    next_cyc();
    #2 check("mis_clear", {31'b0, misalign_o}, 32'd0); check("mis_cnt", {24'b0, redir_cnt_o}, 32'd4);

    // Wrap
    next_cyc(); pc_force = 32'hFFFF_FFFC;
    #2 check("wrap_pc", pc_next_o, 32'h0);

    // Reset while a redirect is pending
    next_cyc(); pc_force = 32'h400; stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h700;
    next_cyc(); stall_i = 1'b1;
    #1 rst = 1'b1;
    #1 check("arst_pc", pc_next_o, RV); check("arst_flush", {31'b0, flush_o}, 32'd1);
    check("arst_mis", {31'b0, misalign_o}, 32'd0); check("arst_cnt", {24'b0, redir_cnt_o}, 32'd0);
    next_cyc(); use_reg = 1'b1;
    #2 check("rb_boot", pc_next_o, 32'h0); check("rb_flush", {31'b0, flush_o}, 32'd1);
    next_cyc(); #2 check("rb_seq4", pc_next_o, 32'h4); check("rb_noflush", {31'b0, flush_o}, 32'd0);
    next_cyc(); #2 check("rb_seq8", pc_next_o, 32'h8);

    // Randomized traffic, checked by the model
    repeat (3000) begin
      next_cyc();
      use_reg     = ($urandom_range(3) != 0);
      pc_force    = $urandom;
      stall_i     = ($urandom_range(9) < 4);
      trap_i      = ($urandom_range(7) == 0);
      mret_i      = ($urandom_range(5) == 0);
      br_taken_i  = ($urandom_range(3) == 0);
      mtvec_i     = $urandom;
      mepc_i      = $urandom;
      br_target_i = $urandom;
      if ($urandom_range(499) == 0) rst = 1'b1;
    end

    // Saturate the counter, then confirm it holds
    repeat (300) begin
      next_cyc(); trap_i = 1'b1; mtvec_i = $urandom;
    end
    next_cyc(); trap_i = 1'b1; mtvec_i = 32'h44;
    #2 check("sat_before", {24'b0, redir_cnt_o}, 32'd255); check("sat_pc", pc_next_o, 32'h44);
    next_cyc();
    #2 check("sat_after", {24'b0, redir_cnt_o}, 32'd255);

    next_cyc();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
